// File: rtl/inert_pkg.sv
// inert_pkg: sequencer states and iNEMO command words shared by the yaw-rate command sequencer.
package inert_pkg;
    typedef enum logic [2:0] {PWRUP, WR1, WR2, WR3, IDLE, RDL, RDH} seq_state_t;
    localparam logic [15:0] CFG_INT = 16'h0D02;
    localparam logic [15:0] CFG_GYR = 16'h1160;
    localparam logic [15:0] CFG_CTL = 16'h1440;
    localparam logic [15:0] RD_YL   = 16'hA600;
    localparam logic [15:0] RD_YH   = 16'hA700;
endpackage

// File: rtl/inert_cmd_seq_sync2.sv
// sync2: two-flop synchronizer with asynchronous active-high reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_ff1, r_ff2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ff1 <= 1'b0;
            r_ff2 <= 1'b0;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end
    assign o_q = r_ff2;
endmodule

// File: rtl/inert_cmd_seq.sv
// inert_cmd_seq: configures the iNEMO after power-up, then reads a 16-bit yaw rate on each data-ready INT.
module inert_cmd_seq
    import inert_pkg::*;
#(
    parameter int STRT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld
);
    seq_state_t        r_state, w_state_nxt;
    logic [STRT_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_wrt, w_wrt_nxt;
    logic              r_vld, w_vld_nxt;
    logic [15:0]       r_cmd, w_cmd_nxt;
    logic [15:0]       r_yaw_rt, w_yaw_rt_nxt;
    logic [7:0]        r_yaw_lo, w_yaw_lo_nxt;
    logic              w_int;
    logic              w_unused;

    sync2 u_int_sync (.clk(clk), .rst(rst), .i_d(INT), .o_q(w_int));

    // The monarch returns a full word but the sensor registers are bytes.
    assign w_unused = ^rd_data[15:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= PWRUP;
            r_cnt    <= '0;
            r_wrt    <= 1'b0;
            r_cmd    <= 16'h0000;
            r_yaw_rt <= 16'h0000;
            r_yaw_lo <= 8'h00;
            r_vld    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wrt    <= w_wrt_nxt;
            r_cmd    <= w_cmd_nxt;
            r_yaw_rt <= w_yaw_rt_nxt;
            r_yaw_lo <= w_yaw_lo_nxt;
            r_vld    <= w_vld_nxt;
        end
    end

    // Counter holds at all-ones once power-up is over; done is only honoured while a transaction is outstanding.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wrt_nxt    = 1'b0;
        w_cmd_nxt    = r_cmd;
        w_yaw_rt_nxt = r_yaw_rt;
        w_yaw_lo_nxt = r_yaw_lo;
        w_vld_nxt    = 1'b0;
        case (r_state)
            PWRUP: begin
                if (&r_cnt) begin
                    w_wrt_nxt   = 1'b1;
                    w_cmd_nxt   = CFG_INT;
                    w_state_nxt = WR1;
                end else begin
                    w_cnt_nxt = r_cnt + STRT_W'(1);
                end
            end
            WR1: begin
                if (done) begin
                    w_wrt_nxt   = 1'b1;
                    w_cmd_nxt   = CFG_GYR;
                    w_state_nxt = WR2;
                end
            end
            WR2: begin
                if (done) begin
                    w_wrt_nxt   = 1'b1;
                    w_cmd_nxt   = CFG_CTL;
                    w_state_nxt = WR3;
                end
            end
            WR3: w_state_nxt = done ? IDLE : WR3;
            IDLE: begin
                if (w_int) begin
                    w_wrt_nxt   = 1'b1;
                    w_cmd_nxt   = RD_YL;
                    w_state_nxt = RDL;
                end
            end
            RDL: begin
                if (done) begin
                    w_yaw_lo_nxt = rd_data[7:0];
                    w_wrt_nxt    = 1'b1;
                    w_cmd_nxt    = RD_YH;
                    w_state_nxt  = RDH;
                end
            end
            RDH: begin
                if (done) begin
                    w_yaw_rt_nxt = {rd_data[7:0], r_yaw_lo};
                    w_vld_nxt    = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = PWRUP;
        endcase
    end

    assign wrt    = r_wrt;
    assign cmd    = r_cmd;
    assign yaw_rt = r_yaw_rt;
    assign vld    = r_vld;
endmodule

// File: tb/tb_inert_cmd_seq.sv
// tb_inert_cmd_seq: drives the sequencer with a behavioural SPI monarch/iNEMO responder and checks commands and yaw results.
module tb_inert_cmd_seq;
    import inert_pkg::*;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, INT, done;
    logic [15:0] rd_data;
    logic        wrt, vld;
    logic [15:0] cmd, yaw_rt;
    int          n_tests = 0;
    int          n_fail = 0;
    int          vld_cnt = 0;
    int          exp_vld = 0;
    bit          hold_int = 1'b0;
    vec_t        tbl[5];

    inert_cmd_seq #(.STRT_W(4)) dut (
        .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .yaw_rt(yaw_rt), .vld(vld)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (vld) vld_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic quiet(input int n);
        bit bad = 1'b0;
        repeat (n) begin
            tick;
            if (wrt || vld) bad = 1'b1;
        end
        chk("quiet", 32'(bad), 0);
    endtask

    // Monarch + sensor: accept one transaction, answer after lat cycles. Reading the high byte clears INT.
    task automatic serve(input logic [15:0] exp_cmd, input logic [7:0] b, input int lat);
        int k = 0;
        bit extra = 1'b0;
        while (!wrt && k < 100) begin
            tick;
            k++;
        end
        chk("wrt_seen", 32'(wrt), 1);
        chk("cmd", 32'(cmd), 32'(exp_cmd));
        if (cmd == RD_YH && !hold_int) INT = 1'b0;
        repeat (lat) begin
            tick;
            if (wrt) extra = 1'b1;
        end
        chk("single_wrt", 32'(extra), 0);
        done = 1'b1;
        rd_data = {8'($urandom), b};
        tick;
        done = 1'b0;
        rd_data = 16'h0000;
    endtask

    // Call at the sample point right after rst is released.
    task automatic init_seq(input bit stray);
        bit early = 1'b0;
        for (int c = 1; c < 16; c++) begin
            tick;
            if (wrt) early = 1'b1;
            done = stray && c == 5;
        end
        done = 1'b0;
        chk("no_early_wrt", 32'(early), 0);
        tick;
        chk("wrt_cycle16", 32'(wrt), 1);
        serve(CFG_INT, 8'($urandom), 2);
        serve(CFG_GYR, 8'($urandom), 3);
        serve(CFG_CTL, 8'($urandom), 4);
    endtask

    task automatic do_read(input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] exp, input int lat);
        INT = 1'b1;
        serve(RD_YL, lo, lat);
        serve(RD_YH, hi, lat);
        exp_vld++;
        chk("vld", 32'(vld), 1);
        chk("yaw_rt", 32'(yaw_rt), 32'(exp));
        tick;
        chk("vld_pulse", 32'(vld), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h34, 8'h12, 16'h1234};
        tbl[1] = '{8'hF0, 8'hFF, 16'hFFF0};
        tbl[2] = '{8'h00, 8'h80, 16'h8000};
        tbl[3] = '{8'hFF, 8'h7F, 16'h7FFF};
        tbl[4] = '{8'h01, 8'h00, 16'h0001};
        rst = 1'b1; INT = 1'b0; done = 1'b0; rd_data = 16'h0000;
        repeat (3) tick;
        chk("rst_wrt", 32'(wrt), 0);
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_yaw", 32'(yaw_rt), 0);
        chk("rst_vld", 32'(vld), 0);
        rst = 1'b0;
        init_seq(1'b1);
        quiet(10);
        chk("vld_count_init", 32'(vld_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            do_read(tbl[i].lo, tbl[i].hi, tbl[i].exp, 2 + i);
            quiet(5);
        end
        // INT held through a read: exactly one more read follows immediately.
        hold_int = 1'b1;
        INT = 1'b1;
        serve(RD_YL, 8'hF0, 3);
        serve(RD_YH, 8'hFF, 3);
        exp_vld++;
        chk("hold_yaw", 32'(yaw_rt), 32'h0000FFF0);
        hold_int = 1'b0;
        tick;
        chk("reread_wrt", 32'(wrt), 1);
        do_read(8'h11, 8'h22, 16'h2211, 3);
        quiet(20);
        // Stray done in IDLE
        done = 1'b1;
        rd_data = 16'(
$urandom);
        tick;
        done = 1'b0;
        quiet(10);
        do_read(8'h56, 8'h78, 16'h7856, 2);
        // Randomized reads against arithmetic model
        for (int i = 0; i < 20; i++) begin
            logic [7:0] lo, hi;
            int v;
            lo = 8'($urandom);
            hi = 8'($urandom);
            v = ((hi >= 8'd128) ? int'(hi) - 256 : int'(hi)) * 256 + int'(lo);
            do_read(lo, hi, v[15:0], int'($urandom_range(2, 7)));
            repeat ($urandom_range(0, 5)) tick;
        end
        chk("vld_count_mid", 32'(vld_cnt), 32'(exp_vld));
        // INT high through power-up and init: one read begins on reaching IDLE.
        rst = 1'b1;
        INT = 1'b1;
        tick;
        rst = 1'b0;
        init_seq(1'b0);
        tick;
        chk("int_after_init_wrt", 32'(wrt), 1);
        do_read(8'h9A, 8'hBC, 16'hBC9A, 3);
        quiet(20);
        // Reset in the middle of RDL
        INT = 1'b1;
        begin
            int k = 0;
            while (!wrt && k < 50) begin
                tick;
                k++;
            end
        end
        chk("rdl_cmd", 32'(cmd), 32'(RD_YL));
        tick;
        tick;
        #2;
        rst = 1'b1;
        #1;
        chk("async_wrt", 32'(wrt), 0);
        chk("async_cmd", 32'(cmd), 0);
        chk("async_yaw", 32'(yaw_rt), 0);
        chk("async_vld", 32'(vld), 0);
        @(posedge clk);
        #1;
        INT = 1'b0;
        rst = 1'b0;
        init_seq(1'b0);
        quiet(5);
        do_read(8'hCD, 8'hAB, 16'hABCD, 4);
        chk("vld_count_end", 32'(vld_cnt), 32'(exp_vld));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/inert_cmd_seq.md
Name: inert_cmd_seq

Overview:
Command sequencer that sits directly upstream of the SPI monarch. It drives the monarch's wrt/wt_data handshake and consumes done/rd_data.
- After reset: waits a power-up interval, then writes three iNEMO configuration registers.
- Thereafter: on each data-ready INT, reads yaw-rate low and high bytes and presents a 16-bit yaw_rt with a one-cycle vld strobe.

Parameters:
STRT_W, 16, width of the power-up wait counter; the wait is 2^STRT_W cycles. Benches set it small, e.g. 4.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
INT  input  1  iNEMO data-ready interrupt; asynchronous, double-flopped internally
done  input  1  SPI monarch transaction complete, one-cycle pulse
rd_data  input  16  SPI monarch read data; only [7:0] is used
wrt  output  1  one-cycle pulse that starts a SPI transaction
cmd  output  16  SPI command word, connects to the monarch's wt_data
yaw_rt  output  16  signed yaw rate, {high byte, low byte}
vld  output  1  one-cycle pulse; yaw_rt was updated on the previous edge

Behaviour:
- Reset (async, rst=1): state=PWRUP; counter=0; wrt=0; cmd=16'h0000; yaw_rt=16'h0000; vld=0; yaw_lo=0; INT synchronizer flops=0.
- All outputs are registered. cmd is loaded in the same edge that raises wrt and holds until the next command is issued.
- Command constants:
  - CFG_INT = 16'h0D02 (INT on gyro data-ready)
  - CFG_GYR = 16'h1160 (gyro ODR 416 Hz)
  - CFG_CTL = 16'h1440 (auto-increment/rounding)
  - RD_YL = 16'hA600
  - RD_YH = 16'hA700
- States and transitions:
  - PWRUP: counter increments every cycle. When it is all-ones: wrt<=1, cmd<=CFG_INT, go to WR1.
  - WR1: on done: wrt<=1, cmd<=CFG_GYR, go to WR2.
  - WR2: on done: wrt<=1, cmd<=CFG_CTL, go to WR3.
  - WR3: on done: go to IDLE.
  - IDLE: on INT_ff2=1: wrt<=1, cmd<=RD_YL, go to RDL.
  - RDL: on done: yaw_lo<=rd_data[7:0], wrt<=1, cmd<=RD_YH, go to RDH.
  - RDH: on done: yaw_rt<={rd_data[7:0], yaw_lo}, vld<=1, go to IDLE.
- Timing and handshake rules:
  - wrt is high for exactly one cycle per transaction.
  - Exactly one transaction is outstanding at any time.
  - done pulses arriving in PWRUP or IDLE are ignored.
- INT handling:
  - INT is level-sensitive after the 2-flop synchronizer.
  - INT high during PWRUP or WR1-WR3 is ignored, not queued.
  - INT still high on return to IDLE starts another read immediately. The sensor clears INT when the high byte is read, so this means genuinely new data.
- Latency: from INT_ff2 high in IDLE, wrt rises at +1 edge, and vld rises 1 cycle after the second done.
- Mid-transaction reset: returns to PWRUP and reruns the full init sequence. The monarch is reset by the same rst.
- The counter saturates or is unused outside PWRUP; it is not reloaded.
- The three init writes ignore rd_data.

Decomposition:
- Package inert_pkg: typedef enum logic [2:0] {PWRUP, WR1, WR2, WR3, IDLE, RDL, RDH} seq_state_t, plus the five 16-bit command localparams.
- One sub-module: sync2 (generic 2-flop synchronizer with async active-high reset), used for INT.
- The state machine, counter and yaw_lo/yaw_rt registers live in inert_cmd_seq.

Test Plan:
1. Reset with STRT_W=4, INT=0, connected to the SPI monarch and iNEMO model -> wrt pulses at cycle 16 with cmd=0D02, then 1160 and 1440 on successive done pulses; state reaches IDLE; vld never asserts.
2. Assert INT after init, with the model yaw registers set to L=8'h34, H=8'h12 -> cmds A600 then A700; one vld pulse with yaw_rt=16'h1234.
3. Negative rate, L=8'hF0, H=8'hFF -> yaw_rt=16'hFFF0. INT held high through the read -> exactly one further read sequence per new assertion.
4. INT high during PWRUP/WR2 -> no read until IDLE. If INT is still high on reaching IDLE, exactly one read starts then, and wrt is never asserted twice in one transaction.
5. Stray done pulse injected in IDLE -> no state change, no wrt, no vld.
6. rst asserted in the middle of RDL -> all outputs go to their reset values asynchronously; after release the full 0D02/1160/1440 sequence repeats before any yaw read.
